memory_lsu: RTL and testbench

//  Stage-4 load/store unit. Accepts one load/store per op from execute, drives the data-memory
//  req/ready + rvalid interface, splits misaligned accesses into two word beats, and

---
 rtl/memory_lsu_pkg.sv | 41 ++++
 rtl/memory_lsu_align.sv | 43 ++++
 rtl/memory_lsu.sv | 139 +++++++++++++
 tb/tb_memory_lsu.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_lsu_pkg.sv
// Shared types and helpers for the stage-4 load/store unit.
// Also used by the commit tracer through lsu_align.
package memory_lsu_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic                we;
    logic [1:0]          size;
    logic                uns;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_req_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ0  = 3'd1;
  localparam logic [2:0] ST_WAIT0 = 3'd2;
  localparam logic [2:0] ST_REQ1  = 3'd3;
  localparam logic [2:0] ST_WAIT1 = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    n = 3'd4;
    if (size == MEM_B) n = 3'd1;
    else if (size == MEM_H) n = 3'd2;
    return n;
  endfunction

  function automatic logic is_split(input logic [1:0] off,
                                    input logic [1:0] size);
    return ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/memory_lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; works on a two-word window {hi, lo}.
module lsu_align
  import memory_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rlo_i,
  input  logic [31:0] rhi_i,
  output logic        split_o,
  output logic [7:0]  strb_o,
  output logic [63:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  mask;
  logic [31:0] rsh;
  logic [5:0]  sh;

  always_comb begin
    sh      = {1'b0, off_i, 3'b000};
    split_o = is_split(off_i, size_i);
    rsh     = 32'({rhi_i, rlo_i} >> sh);
    mask    = 8'h0F;
    rdata_o = rsh;
    unique case (1'b1)
      (size_i == MEM_B): begin
        mask    = 8'h01;
        rdata_o = {{24{~uns_i & rsh[7]}}, rsh[7:0]};
      end
      (size_i == MEM_H): begin
        mask    = 8'h03;
        rdata_o = {{16{~uns_i & rsh[15]}}, rsh[15:0]};
      end
      default: ;
    endcase
    strb_o  = mask << off_i;
    wdata_o = {32'b0, wdata_i} << sh;
  end

endmodule

// File: rtl/memory_lsu.sv
// Stage-4 load/store unit: FSM, beat registers and dmem handshake.
// Misaligned accesses are issued as two word beats when SPLIT_MISAL=1.
module memory_lsu
  import memory_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit SPLIT_MISAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            req_valid_i,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_wstrb_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ready_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            misal_o,
  output logic [XLEN-1:0] read_data_o
);

  logic [2:0]      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [XLEN-1:0] beat0_q, beat0_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            beat1, split, done, misal;
  logic [7:0]      strb;
  logic [63:0]     wd64;
  logic [XLEN-1:0] ld_lo, ld_data;

  assign ld_lo = (state_q == ST_WAIT1) ? beat0_q : dmem_rdata_i;

  lsu_align u_align (
    .off_i   (req_q.addr[1:0]),
    .size_i  (req_q.size),
    .uns_i   (req_q.uns),
    .wdata_i (req_q.wdata),
    .rlo_i   (ld_lo),
    .rhi_i   (dmem_rdata_i),
    .split_o (split),
    .strb_o  (strb),
    .wdata_o (wd64),
    .rdata_o (ld_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    beat0_d = beat0_q;
    rdata_d = rdata_q;
    done    = 1'b0;
    misal   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && !flush_i) begin
          if (!SPLIT_MISAL && is_split(req_addr_i[1:0], req_size_i)) begin
            misal = 1'b1;
          end else begin
            req_d = '{we: req_we_i, size: req_size_i,
                      uns: req_unsigned_i, addr: req_addr_i,
                      wdata: req_wdata_i};
            state_d = ST_REQ0;
          end
        end
      end
      ST_REQ0, ST_REQ1: begin
        if (flush_i) begin
          state_d = dmem_ready_i ? ST_DRAIN : ST_IDLE;
        end else if (dmem_ready_i) begin
          state_d = (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
        end
      end
      ST_WAIT0, ST_WAIT1: begin
        // a response arriving with the flush is the one we would drain
        if (dmem_rvalid_i) begin
          if (flush_i) begin
            state_d = ST_IDLE;
          end else if (state_q == ST_WAIT0 && split) begin
            beat0_d = dmem_rdata_i;
            state_d = ST_REQ1;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dmem_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (done && !req_q.we) rdata_d = ld_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      beat0_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      beat0_q <= beat0_d;
      rdata_q <= rdata_d;
    end
  end

  assign beat1        = (state_q == ST_REQ1);
  assign dmem_req_o   = (state_q == ST_REQ0) || beat1;
  assign dmem_we_o    = dmem_req_o & req_q.we;
  assign dmem_addr_o  = {req_q.addr[XLEN-1:2], 2'b00}
                      + {{(XLEN-3){1'b0}}, beat1, 2'b00};
  assign dmem_wstrb_o = !dmem_req_o ? 4'b0
                      : (beat1 ? strb[7:4] : strb[3:0]);
  assign dmem_wdata_o = beat1 ? wd64[63:32] : wd64[31:0];
  assign busy_o       = (state_q != ST_IDLE) || req_valid_i;
  assign done_o       = done;
  assign misal_o      = misal;
  assign read_data_o  = rdata_d;

  a_rvalid_expected: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    dmem_rvalid_i |-> (state_q == ST_WAIT0 || state_q == ST_WAIT1 ||
                       state_q == ST_DRAIN));

endmodule

// File: tb/tb_memory_lsu.sv
// Self-checking bench for memory_lsu: acts as data memory and
// scoreboards read_data_o against expected values at every done_o.
module tb_memory_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic        misal_o;
  logic [31:0] read_data_o;

  memory_lsu #(.XLEN(32), .SPLIT_MISAL(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wstrb_o   (dmem_wstrb_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ready_i   (dmem_ready_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .misal_o        (misal_o),
    .read_data_o    (read_data_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0, last_done_cyc, done_cnt = 0;
  int          nbeats, stable_err;
  int          req_wait [2];
  logic        done_at [2];
  logic [31:0] b_addr [2];
  logic [3:0]  b_strb [2];
  logic [31:0] b_wdata [2];
  logic        b_we [2];
  logic [31:0] exp_q [$];
  logic [31:0] model_rd = '0;
  logic        misal_seen = 1'b0;

  always @(posedge clk_i) cyc++;

  // scoreboard: every completed op must match the oldest expectation
  always @(negedge clk_i) begin
    if (rst_ni && misal_o) misal_seen = 1'b1;
    if (rst_ni && done_o) begin
      logic [31:0] e;
      done_cnt++;
      last_done_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got %h expected none",
                 read_data_o);
      end else begin
        e = exp_q.pop_front();
        if (read_data_o !== e) begin
          errors++;
          $display("FAIL sb_read_data got %h expected %h",
                   read_data_o, e);
        end
      end
    end
  end

  task automatic present(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
    t0 = cyc;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] r0,
                        input logic [31:0] r1, input int dly);
    int n;
    nbeats = 0; stable_err = 0;
    done_at[0] = 1'b0; done_at[1] = 1'b0;
    present(we, sz, uns, a, wd);
    for (int b = 0; b < 2; b++) begin
      if (b == 1 && !busy_o) break;
      n = 0;
      while (!dmem_req_o && n < 8) begin
        @(posedge clk_i); #1; n++;
      end
      if (!dmem_req_o) begin
        checks++; errors++;
        $display("FAIL req_timeout beat %0d got no dmem_req_o", b);
        break;
      end
      req_wait[b] = n;
      b_addr[b] = dmem_addr_o; b_strb[b] = dmem_wstrb_o;
      b_wdata[b] = dmem_wdata_o; b_we[b] = dmem_we_o;
      repeat (dly) begin
        @(posedge clk_i); #1;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== b_addr[b] ||
            dmem_wstrb_o !== b_strb[b] ||
            dmem_wdata_o !== b_wdata[b] || busy_o !== 1'b1)
          stable_err++;
      end
      dmem_ready_i = 1'b1;
      @(posedge clk_i); #1;
      dmem_ready_i = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i = (b == 0) ? r0 : r1;
      #3;
      done_at[b] = done_o;
      @(posedge clk_i); #1;
      dmem_rvalid_i = 1'b0;
      nbeats++;
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; flush_i = 0; req_valid_i = 0; req_we_i = 0;
    req_size_i = 0; req_unsigned_i = 0; req_addr_i = 0;
    req_wdata_i = 0; dmem_ready_i = 0; dmem_rvalid_i = 0;
    dmem_rdata_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, busy_o, done_o, misal_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000",
               {dmem_req_o, dmem_we_o, busy_o, done_o, misal_o});
    end
    checks++;
    if ({dmem_addr_o, dmem_wstrb_o, dmem_wdata_o, read_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h expected 0",
               dmem_addr_o, dmem_wstrb_o, dmem_wdata_o, read_data_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_lw;
    exp_q.push_back(32'hDEADBEEF); model_rd = 32'hDEADBEEF;
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
    checks++;
    if (b_addr[0] !== 32'h100 || b_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL lw_addr got %h we %b expected 00000100 we 0",
               b_addr[0], b_we[0]);
    end
    checks++;
    if (req_wait[0] !== 0 || nbeats !== 1) begin
      errors++;
      $display("FAIL lw_accept got wait %0d beats %0d expected 0 1",
               req_wait[0], nbeats);
    end
    checks++;
    if (last_done_cyc - t0 !== 2) begin
      errors++;
      $display("FAIL lw_latency got %0d expected 2", last_done_cyc - t0);
    end
  endtask

  task automatic test_lb;
    exp_q.push_back(32'hFFFFFF80);
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 0);
    exp_q.push_back(32'h00000080); model_rd = 32'h00000080;
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 0);
    checks++;
    if (b_addr[0] !== 32'h100 || nbeats !== 1) begin
      errors++;
      $display("FAIL lb_addr got %h beats %0d expected 00000100 1",
               b_addr[0], nbeats);
    end
  endtask

  task automatic test_sw_split;
    exp_q.push_back(model_rd);
    run_op(1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 0, 0, 0);
    checks++;
    if (nbeats !== 2 || b_addr[0] !== 32'h100 || b_addr[1] !== 32'h104) begin
      errors++;
      $display("FAIL sw_addrs got %0d %h %h expected 2 00000100 00000104",
               nbeats, b_addr[0], b_addr[1]);
    end
    checks++;
    if (b_strb[0] !== 4'b1100 || b_strb[1] !== 4'b0011 ||
        b_we[0] !== 1'b1 || b_we[1] !== 1'b1) begin
      errors++;
      $display("FAIL sw_strb got %b %b we %b%b expected 1100 0011 we 11",
               b_strb[0], b_strb[1], b_we[0], b_we[1]);
    end
    checks++;
    if (b_wdata[0][31:16] !== 16'h3344 || b_wdata[1][15:0] !== 16'h1122) begin
      errors++;
      $display("FAIL sw_wdata got %h %h expected 3344xxxx xxxx1122",
               b_wdata[0], b_wdata[1]);
    end
    checks++;
    if (done_at[0] !== 1'b0 || done_at[1] !== 1'b1) begin
      errors++;
      $display("FAIL sw_done got %b%b expected 01", done_at[0], done_at[1]);
    end
  endtask

  task automatic test_lh_wrap;
    exp_q.push_back(32'hFFFFBBAA); model_rd = 32'hFFFFBBAA;
    run_op(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 0,
           32'hAA000000, 32'h000000BB, 0);
    checks++;
    if (nbeats !== 2 || b_addr[0] !== 32'hFFFFFFFC ||
        b_addr[1] !== 32'h0) begin
      errors++;
      $display("FAIL lh_wrap got %0d %h %h expected 2 fffffffc 00000000",
               nbeats, b_addr[0], b_addr[1]);
    end
  endtask

  task automatic test_flush_wait0;
    int dc;
    int req_seen;
    dc = done_cnt; req_seen = 0;
    present(1'b0, 2'b10, 1'b0, 32'h101, 0);
    dmem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_ready_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain got busy %b req %b expected 1 0",
               busy_o, dmem_req_o);
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    repeat (3) begin
      if (dmem_req_o !== 1'b0 || busy_o !== 1'b0) req_seen++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (req_seen !== 0 || done_cnt !== dc) begin
      errors++;
      $display("FAIL flush_no_beat1 got req %0d done %0d expected 0 %0d",
               req_seen, done_cnt, dc);
    end
    checks++;
    if (read_data_o !== model_rd) begin
      errors++;
      $display("FAIL flush_rdata got %h expected %h", read_data_o, model_rd);
    end
    exp_q.push_back(32'hCAFEF00D); model_rd = 32'hCAFEF00D;
    run_op(1'b0, 2'b10, 1'b0, 32'h300, 0, 32'hCAFEF00D, 0, 0);
    checks++;
    if (nbeats !== 1 || b_addr[0] !== 32'h300) begin
      errors++;
      $display("FAIL flush_next got %0d %h expected 1 00000300",
               nbeats, b_addr[0]);
    end
  endtask

  task automatic test_flush_req0;
    present(1'b1, 2'b10, 1'b0, 32'h400, 32'h55);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    checks++;
    if (dmem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_req0 got req %b busy %b expected 0 0",
               dmem_req_o, busy_o);
    end
    present(1'b1, 2'b10, 1'b0, 32'h400, 32'h55);
    flush_i = 1'b1; dmem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; dmem_ready_i = 1'b0;
    checks++;
    if (dmem_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_accept got req %b busy %b expected 0 1",
               dmem_req_o, busy_o);
    end
    dmem_rvalid_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_drained got busy %b expected 0", busy_o);
    end
  endtask

  task automatic test_stall;
    exp_q.push_back(model_rd);
    run_op(1'b1, 2'b01, 1'b0, 32'h200, 32'h1234ABCD, 0, 0, 5);
    checks++;
    if (stable_err !== 0) begin
      errors++;
      $display("FAIL stall_stable got %0d unstable cycles expected 0",
               stable_err);
    end
    checks++;
    if (b_addr[0] !== 32'h200 || b_strb[0] !== 4'b0011 ||
        b_wdata[0][15:0] !== 16'hABCD) begin
      errors++;
      $display("FAIL stall_fields got %h %b %h expected 00000200 0011 xxxxabcd",
               b_addr[0], b_strb[0], b_wdata[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, r;
    int off;
    for (int i = 0; i < 4; i++) begin
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      r = $urandom;
      exp_q.push_back(r); model_rd = r;
      run_op(1'b0, 2'b10, 1'b0, a, 0, r, 0, 0);
      checks++;
      if (b_addr[0] !== a || last_done_cyc - t0 !== 2) begin
        errors++;
        $display("FAIL b2b_lw got %h lat %0d expected %h lat 2",
                 b_addr[0], last_done_cyc - t0, a);
      end
    end
    for (int i = 0; i < 3; i++) begin
      off = $urandom_range(0, 3);
      exp_q.push_back(model_rd);
      run_op(1'b1, 2'b00, 1'b0, 32'h500 + off, 32'hFFFFFFA5, 0, 0, 0);
      checks++;
      if (b_strb[0] !== 4'(1 << off) || nbeats !== 1 ||
          8'(b_wdata[0] >> (8 * off)) !== 8'hA5) begin
        errors++;
        $display("FAIL b2b_sb got %b %h beats %0d off %0d",
                 b_strb[0], b_wdata[0], nbeats, off);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    present(1'b0, 2'b10, 1'b0, 32'h102, 0);
    dmem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_ready_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BADF00D;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    dmem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_ready_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || read_data_o === 32'h0) begin
      errors++;
      $display("FAIL pre_reset got busy %b rd %h expected 1 nonzero",
               busy_o, read_data_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, busy_o, done_o, misal_o} !== 5'b0 ||
        {dmem_addr_o, dmem_wstrb_o, dmem_wdata_o, read_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op got %b %h %h %h %h expected all 0",
               {dmem_req_o, dmem_we_o, busy_o, done_o, misal_o},
               dmem_addr_o, dmem_wstrb_o, dmem_wdata_o, read_data_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    model_rd = '0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sw_split();
    test_lh_wrap();
    test_flush_wait0();
    test_flush_req0();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() !== 0 || misal_seen !== 1'b0) begin
      errors++;
      $display("FAIL end_state got %0d pending misal %b expected 0 0",
               exp_q.size(), misal_seen);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
